// File: rtl/store_unit.sv
//------------------------------------------------------------------------------
// Module      : store_unit
// Description : Store-side data path for the multicycle RISC-V core. Accepts
//               one store request (address, rs2 data, funct3), forms byte
//               lanes and lane-shifted write data, and drives a word-addressed
//               data-memory write port with a request/grant handshake.
//               Optional feature macro: STORE_MISALIGNED_SPLIT_EN. When it is
//               defined, word-crossing SH/SW are issued as two writes (low
//               word, then high word). When it is undefined, they are
//               rejected with err_o.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [2:0]      funct3_i,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_be_o,
    output logic            done_o,
    output logic            err_o
);

    // FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ACC0 = 2'd1;
`ifdef STORE_MISALIGNED_SPLIT_EN
    localparam logic [1:0] c_ST_ACC1 = 2'd2;
`endif

    // Store size encodings carried in funct3
    localparam logic [2:0] c_F3_SB = 3'b000;
    localparam logic [2:0] c_F3_SH = 3'b001;
    localparam logic [2:0] c_F3_SW = 3'b010;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [3:0]      r_mem_be;
    logic            r_done;
    logic            r_err;

    logic            w_accept;
    logic [1:0]      w_off;
    logic [2:0]      w_size;
    logic [2:0]      w_end;
    logic [3:0]      w_base_be;
    logic [XLEN-1:0] w_data_sized;
    logic            w_illegal;
    logic            w_cross;
    logic            w_reject;
    logic [XLEN-1:0] w_word_addr;

`ifdef STORE_MISALIGNED_SPLIT_EN
    // High-word half of a split store, parked until the low word is granted
    logic            r_split;
    logic [XLEN-1:0] r_hi_wdata;
    logic [3:0]      r_hi_be;
    logic [63:0]     w_lane;
    logic [7:0]      w_mask;
`else
    // Crossing stores are rejected, so lanes never spill past one word
    logic [XLEN-1:0] w_lane;
    logic [3:0]      w_mask;
`endif

    // Handshake: ready only when idle and not being reset
    assign req_ready_o = (r_state == c_ST_IDLE) && !rst_i;
    assign w_accept    = req_valid_i && req_ready_o;

    // Size decode and zero-extension of the stored bytes
    always_comb begin
        w_size       = 3'd0;
        w_base_be    = 4'b0000;
        w_data_sized = '0;
        w_illegal    = 1'b0;
        case (funct3_i)
            c_F3_SB: begin
                w_size       = 3'd1;
                w_base_be    = 4'b0001;
                w_data_sized = {24'd0, data_i[7:0]};
            end
            c_F3_SH: begin
                w_size       = 3'd2;
                w_base_be    = 4'b0011;
                w_data_sized = {16'd0, data_i[15:0]};
            end
            c_F3_SW: begin
                w_size       = 3'd4;
                w_base_be    = 4'b1111;
                w_data_sized = data_i;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_off       = addr_i[1:0];
    assign w_end       = {1'b0, w_off} + w_size;
    assign w_cross     = (w_end > 3'd4);
    assign w_word_addr = {addr_i[XLEN-1:2], 2'b00};

`ifdef STORE_MISALIGNED_SPLIT_EN
    // 64-bit lane view: low word goes to the first access, high to the second
    assign w_lane   = {32'd0, w_data_sized} << {w_off, 3'b000};
    assign w_mask   = {4'd0, w_base_be} << w_off;
    assign w_reject = w_illegal;
`else
    assign w_lane   = w_data_sized << {w_off, 3'b000};
    assign w_mask   = w_base_be << w_off;
    assign w_reject = w_illegal || w_cross;
`endif

    // Control FSM and registered memory-port / status outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= 4'b0000;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
            r_split     <= 1'b0;
            r_hi_wdata  <= '0;
            r_hi_be     <= 4'b0000;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_reject) begin
                            // Rejected stores never touch memory
                            r_err <= 1'b1;
                        end else begin
                            r_state     <= c_ST_ACC0;
                            r_mem_addr  <= w_word_addr;
                            r_mem_wdata <= w_lane[31:0];
                            r_mem_be    <= w_mask[3:0];
`ifdef STORE_MISALIGNED_SPLIT_EN
                            r_split     <= w_cross;
                            r_hi_wdata  <= w_lane[63:32];
                            r_hi_be     <= w_mask[7:4];
`endif
                        end
                    end
                end
                c_ST_ACC0: begin
                    if (mem_gnt_i) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
                        if (r_split) begin
                            // Second access follows with no request gap
                            r_state     <= c_ST_ACC1;
                            r_mem_addr  <= r_mem_addr + XLEN'(4);
                            r_mem_wdata <= r_hi_wdata;
                            r_mem_be    <= r_hi_be;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end
`else
                        r_state <= c_ST_IDLE;
                        r_done  <= 1'b1;
`endif
                    end
                end
`ifdef STORE_MISALIGNED_SPLIT_EN
                c_ST_ACC1: begin
                    if (mem_gnt_i) begin
                        r_state <= c_ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = (r_state != c_ST_IDLE);
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_be_o    = r_mem_be;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_store_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_store_unit
// Description : Self-checking bench for store_unit. Directed scenarios plus
//               randomized stores compared against a byte-level model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_store_unit;

`ifdef STORE_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [2:0]  funct3_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        done_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected result of the store currently being modelled
    bit          exp_err;
    int          exp_n;
    logic [31:0] exp_addr [2];
    logic [31:0] exp_data [2];
    logic [3:0]  exp_be   [2];

    store_unit #(.XLEN(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .funct3_i    (funct3_i),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Byte-by-byte placement of the store into word-sized memory writes
    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        int size;
        int off;
        case (f3)
            3'b000:  size = 1;
            3'b001:  size = 2;
            3'b010:  size = 4;
            default: size = 0;
        endcase
        off = int'(a[1:0]);
        exp_addr[0] = a & ~32'h3;
        exp_addr[1] = exp_addr[0] + 32'd4;
        exp_data[0] = '0;
        exp_data[1] = '0;
        exp_be[0]   = '0;
        exp_be[1]   = '0;
        exp_err     = (size == 0) || ((off + size > 4) && !SPLIT_EN);
        exp_n       = (off + size > 4) ? 2 : 1;
        for (int i = 0; i < size; i++) begin
            int pos;
            int idx;
            int lane;
            pos  = off + i;
            idx  = pos / 4;
            lane = pos % 4;
            exp_data[idx] = exp_data[idx] | (((d >> (8 * i)) & 32'hFF) << (8 * lane));
            exp_be[idx]   = exp_be[idx] | 4'(1 << lane);
        end
    endtask

    // Drive one store and check every cycle until done/err. Entered just
    // after a falling edge in a cycle where the unit should be idle.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                             input int dly0, input int dly1);
        int dly;
        check_val("ready_before_accept", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        addr_i      = a;
        data_i      = d;
        funct3_i    = f3;
        mem_gnt_i   = 1'($urandom_range(0, 1));
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        addr_i      = $urandom;
        data_i      = $urandom;
        funct3_i    = 3'($urandom_range(0, 7));
        model_store(a, d, f3);
        @(negedge clk_i);
        if (exp_err) begin
            check_val("err_pulse", 32'(err_o), 32'd1);
            check_val("err_no_req", 32'(mem_req_o), 32'd0);
            check_val("err_no_done", 32'(done_o), 32'd0);
            check_val("err_ready", 32'(req_ready_o), 32'd1);
            mem_gnt_i = 1'b0;
            return;
        end
        for (int k = 0; k < exp_n; k++) begin
            dly = (k == 0) ? dly0 : dly1;
            for (int g = 0; g <= dly; g++) begin
                check_val("req_high", 32'(mem_req_o), 32'd1);
                check_val("mem_addr", mem_addr_o, exp_addr[k]);
                check_val("mem_wdata", mem_wdata_o, exp_data[k]);
                check_val("mem_be", 32'(mem_be_o), 32'(exp_be[k]));
                check_val("no_done_busy", 32'(done_o), 32'd0);
                check_val("no_err_busy", 32'(err_o), 32'd0);
                check_val("not_ready_busy", 32'(req_ready_o), 32'd0);
                mem_gnt_i = (g == dly);
                @(negedge clk_i);
            end
        end
        check_val("done_pulse", 32'(done_o), 32'd1);
        check_val("done_no_err", 32'(err_o), 32'd0);
        check_val("done_req_low", 32'(mem_req_o), 32'd0);
        check_val("done_ready", 32'(req_ready_o), 32'd1);
        mem_gnt_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        addr_i      = '0;
        data_i      = '0;
        funct3_i    = '0;
        mem_gnt_i   = 1'b0;
        repeat (3) @(negedge clk_i);

        // Reset state
        check_val("rst_req", 32'(mem_req_o), 32'd0);
        check_val("rst_addr", mem_addr_o, 32'd0);
        check_val("rst_wdata", mem_wdata_o, 32'd0);
        check_val("rst_be", 32'(mem_be_o), 32'd0);
        check_val("rst_done", 32'(done_o), 32'd0);
        check_val("rst_err", 32'(err_o), 32'd0);
        check_val("rst_ready", 32'(req_ready_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Directed cases
        run_store(32'h0000_2003, 32'h1234_5678, 3'b000, 0, 0);
        run_store(32'h0000_3001, 32'h0000_BEEF, 3'b001, 3, 0);
        run_store(32'h0000_1002, 32'hAABB_CCDD, 3'b010, 0, 0);
        run_store(32'h0000_1002, 32'hAABB_CCDD, 3'b010, 2, 1);
        run_store(32'h0000_0000, 32'h0000_0000, 3'b011, 0, 0);
        run_store(32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 0, 0);
        run_store(32'h0000_0100, 32'h1111_1111, 3'b010, 0, 0);
        run_store(32'h0000_0104, 32'h2222_2222, 3'b010, 0, 0);
        run_store(32'hFFFF_FFFF, 32'h0102_0304, 3'b001, 1, 1);
        run_store(32'h0000_0000, 32'h0000_0000, 3'b111, 0, 0);
        run_store(32'h0000_0000, 32'h0000_0000, 3'b100, 0, 0);

        // Reset during an in-flight store aborts it without done/err
        req_valid_i = 1'b1;
        funct3_i    = 3'b010;
        data_i      = 32'hAABB_CCDD;
`ifdef STORE_MISALIGNED_SPLIT_EN
        addr_i      = 32'h0000_1002;
`else
        addr_i      = 32'h0000_1000;
`endif
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        check_val("abort_req_acc0", 32'(mem_req_o), 32'd1);
`ifdef STORE_MISALIGNED_SPLIT_EN
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        check_val("abort_req_acc1", 32'(mem_req_o), 32'd1);
        check_val("abort_addr_acc1", mem_addr_o, 32'h0000_1004);
`endif
        mem_gnt_i = 1'b0;
        rst_i     = 1'b1;
        @(negedge clk_i);
        check_val("abort_req_low", 32'(mem_req_o), 32'd0);
        check_val("abort_no_done", 32'(done_o), 32'd0);
        check_val("abort_no_err", 32'(err_o), 32'd0);
        check_val("abort_ready_rst", 32'(req_ready_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_val("abort_no_done2", 32'(done_o), 32'd0);
        check_val("abort_req_low2", 32'(mem_req_o), 32'd0);
        run_store(32'h0000_0041, 32'h0000_00A5, 3'b000, 1, 0);

        // Randomized stores
        for (int t = 0; t < 200; t++) begin
            logic [31:0] ra;
            logic [31:0] rd;
            logic [2:0]  rf;
            ra = $urandom;
            rd = $urandom;
            rf = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            run_store(ra, rd, rf, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
